multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multicycle successor to the single-cycle MIPS controller. It sequences each instruction over several clocks, sharing one ALU and one memory port, and adds a memory wait-state handshake with timeout. It decodes the same instruction set: R-type (add/sub/and/or/slt/nor/xor/jr), lw/lh/lb/lbu, sw/sh/sb, beq/bne, addi, j and jal. Branch resolution (zero XOR ne) is folded into the `pcen` output.

## Interface
- ALUCTRL_W, 4, width of `alucontrol`, must be ≥4; upper bits above [3:0] are driven 0.
- ENABLE_LINK, 1, 1 = jal supported; 0 = jal opcode treated as illegal.
- MAX_WAIT, 15, maximum number of not-ready cycles in a memory state before bus error; 0 = no timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low.
- op, funct  in  6 each  instruction fields from the IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pcen, irwrite, regwrite, memread, memwrite, iord  out  1 each.
- alusrca  out  1  0 = PC, 1 = A.
- alusrcb  out  2  00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2.
- pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target, 11 = A (jr).
- regdst  out  2  00 = rt, 01 = rd, 10 = $31.
- memtoreg  out  2  00 = ALUOut, 01 = mem data, 10 = PC.
- half, b, lbu  out  1 each  access-size qualifiers, valid in MEMRD, MEMWB and MEMWR.
- alucontrol  out  ALUCTRL_W  ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, NOR 1100, XOR 0011.
- illegal, buserr  out  1 each  single-cycle error pulses.
- state  out  4  current state encoding.

## Operation
- Moore FSM. State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, ADDIEX 8, ADDIWB 9, BRANCH 10, JUMP 11, JR 12.
- Any output not listed for a state is 0. Exception: `alucontrol` defaults to ADD.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, pcsrc=00. pcen=irwrite=mem_ready. Go to DECODE on mem_ready.
- DECODE: alusrca=0, alusrcb=11 (branch target into ALUOut). Dispatch:
  - loads/stores → MEMADR
  - R-type → EXEC, or JR when funct=001000
  - beq/bne → BRANCH
  - addi → ADDIEX
  - j/jal → JUMP
  - anything else, including an unknown funct → FETCH with illegal=1.
- MEMADR: alusrca=1, alusrcb=10. Next is MEMRD for loads, MEMWR for stores.
- MEMRD: memread=1, iord=1. Go to MEMWB on mem_ready.
- MEMWB: regwrite=1, regdst=00, memtoreg=01. Then FETCH.
- MEMWR: memwrite=1, iord=1. Go to FETCH on mem_ready.
- half/b/lbu assertion:
  - lh/sh → half=1
  - lb/sb → b=1
  - lbu → b=1 and lbu=1.
- EXEC: alusrca=1, alusrcb=00, alucontrol taken from funct. Then ALUWB.
- ALUWB: regwrite=1, regdst=01, memtoreg=00. Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, ADD. Then ADDIWB.
- ADDIWB: regwrite=1, regdst=00, memtoreg=00. Then FETCH.
- BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01, pcen = zero XOR (op==bne). Then FETCH.
- JUMP: pcsrc=10, pcen=1. For jal also regwrite=1, regdst=10, memtoreg=10; the PC still holds PC+4 in this cycle. Then FETCH.
- JR: pcsrc=11, pcen=1. Then FETCH.

## Timing
- Reset low: state=FETCH and wait counter=0. All outputs are forced to 0 while reset is low, including pcen, irwrite and memwrite. First fetch happens in the first cycle after deassertion.
- Wait counter (width $clog2(MAX_WAIT+1)):
  - clears on entry to FETCH, MEMRD or MEMWR;
  - increments each cycle those states see mem_ready=0.
- Timeout: mem_ready=0 with counter==MAX_WAIT (MAX_WAIT>0) → buserr=1 that cycle, pcen/irwrite/memwrite forced 0, next state FETCH.
  - In FETCH the same instruction is then refetched.
- Simultaneous mem_ready=1 with counter==MAX_WAIT: ready wins, normal completion, no buserr.
- Latency with mem_ready held at 1:
  - R-type / addi: 4 cycles
  - lw: 5
  - sw: 4
  - branch, j, jal, jr: 3
- Each cycle of mem_ready=0 in a memory state adds one cycle.
- Reset asserted mid-instruction aborts it immediately. No write strobe is issued after the reset edge.

## Test plan
- add (op=0, funct=100000), mem_ready=1: states 0→1→6→7→0. alucontrol=0010 in EXEC. regwrite=1 with regdst=01 only in ALUWB.
- lw with mem_ready low for 3 cycles in MEMRD: states 0,1,2,3,3,3,3,4,0. regwrite asserted exactly once, memtoreg=01.
- beq with zero=1 → pcen=1, pcsrc=01 in BRANCH. bne with zero=1 → pcen=0. Both return to FETCH in cycle 3.
- jal with ENABLE_LINK=1: JUMP asserts pcen, regwrite, regdst=10, memtoreg=10. Same opcode with ENABLE_LINK=0 gives illegal pulse in DECODE, then FETCH.
- MAX_WAIT=3, mem_ready stuck 0 in MEMWR: buserr on the 4th wait cycle, memwrite=0 that cycle, then state=0. mem_ready=1 on that same cycle instead gives no buserr.
- Reset asserted in MEMWR while memwrite=1: memwrite drops asynchronously and state=0. After release the FETCH sequence restarts.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Multicycle MIPS control FSM with a memory wait-state timeout.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int ALUCTRL_W   = 4,
    parameter bit ENABLE_LINK = 1'b1,
    parameter int MAX_WAIT    = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pcen,
    output logic                 irwrite,
    output logic                 regwrite,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 iord,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [1:0]           regdst,
    output logic [1:0]           memtoreg,
    output logic                 half,
    output logic                 b,
    output logic                 lbu,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal,
    output logic                 buserr,
    output logic [3:0]           state
);

    localparam logic [3:0] c_ST_FETCH  = 4'd0;
    localparam logic [3:0] c_ST_DECODE = 4'd1;
    localparam logic [3:0] c_ST_MEMADR = 4'd2;
    localparam logic [3:0] c_ST_MEMRD  = 4'd3;
    localparam logic [3:0] c_ST_MEMWB  = 4'd4;
    localparam logic [3:0] c_ST_MEMWR  = 4'd5;
    localparam logic [3:0] c_ST_EXEC   = 4'd6;
    localparam logic [3:0] c_ST_ALUWB  = 4'd7;
    localparam logic [3:0] c_ST_ADDIEX = 4'd8;
    localparam logic [3:0] c_ST_ADDIWB = 4'd9;
    localparam logic [3:0] c_ST_BRANCH = 4'd10;
    localparam logic [3:0] c_ST_JUMP   = 4'd11;
    localparam logic [3:0] c_ST_JR     = 4'd12;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_LH    = 6'b100001;
    localparam logic [5:0] c_OP_LB    = 6'b100000;
    localparam logic [5:0] c_OP_LBU   = 6'b100100;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_SH    = 6'b101001;
    localparam logic [5:0] c_OP_SB    = 6'b101000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;

    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;
    localparam logic [5:0] c_FN_NOR = 6'b100111;
    localparam logic [5:0] c_FN_XOR = 6'b100110;
    localparam logic [5:0] c_FN_JR  = 6'b001000;

    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;
    localparam logic [3:0] c_ALU_NOR = 4'b1100;
    localparam logic [3:0] c_ALU_XOR = 4'b0011;

    localparam int                 c_CNT_W      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LIMIT = c_CNT_W'(MAX_WAIT);

    logic [3:0]         r_state;
    logic [3:0]         w_next_state;
    logic [c_CNT_W-1:0] r_wait_cnt;

    logic w_mem_state, w_timeout;
    logic w_is_rtype, w_is_jr, w_is_load, w_is_store, w_is_branch, w_is_addi;
    logic w_is_jal, w_is_jump, w_funct_ok, w_decode_ok;
    logic [3:0] w_funct_alu;

    logic       w_pcen, w_irwrite, w_regwrite, w_memread, w_memwrite, w_iord, w_alusrca;
    logic [1:0] w_alusrcb, w_pcsrc, w_regdst, w_memtoreg;
    logic       w_half, w_b, w_lbu, w_illegal, w_buserr;
    logic [3:0] w_aluc, w_aluc_gated;

    assign w_mem_state = (r_state == c_ST_FETCH) || (r_state == c_ST_MEMRD) ||
                         (r_state == c_ST_MEMWR);
    assign w_timeout   = (MAX_WAIT > 0) && w_mem_state && !mem_ready &&
                         (r_wait_cnt == c_WAIT_LIMIT);

    assign w_is_rtype  = (op == c_OP_RTYPE);
    assign w_is_jr     = w_is_rtype && (funct == c_FN_JR);
    assign w_is_load   = (op == c_OP_LW) || (op == c_OP_LH) || (op == c_OP_LB) ||
                         (op == c_OP_LBU);
    assign w_is_store  = (op == c_OP_SW) || (op == c_OP_SH) || (op == c_OP_SB);
    assign w_is_branch = (op == c_OP_BEQ) || (op == c_OP_BNE);
    assign w_is_addi   = (op == c_OP_ADDI);
    assign w_is_jal    = ENABLE_LINK && (op == c_OP_JAL);
    assign w_is_jump   = (op == c_OP_J) || w_is_jal;
    assign w_decode_ok = w_is_load || w_is_store || w_is_branch || w_is_addi || w_is_jump ||
                         (w_is_rtype && (w_is_jr || w_funct_ok));

    always_comb begin
        w_funct_alu = c_ALU_ADD;
        w_funct_ok  = 1'b1;
        case (funct)
            c_FN_ADD: w_funct_alu = c_ALU_ADD;
            c_FN_SUB: w_funct_alu = c_ALU_SUB;
            c_FN_AND: w_funct_alu = c_ALU_AND;
            c_FN_OR:  w_funct_alu = c_ALU_OR;
            c_FN_SLT: w_funct_alu = c_ALU_SLT;
            c_FN_NOR: w_funct_alu = c_ALU_NOR;
            c_FN_XOR: w_funct_alu = c_ALU_XOR;
            default:  w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = c_ST_FETCH;
        case (r_state)
            c_ST_FETCH:  w_next_state = mem_ready ? c_ST_DECODE : c_ST_FETCH;
            c_ST_DECODE: begin
                if (w_is_load || w_is_store)           w_next_state = c_ST_MEMADR;
                else if (w_is_jr)                      w_next_state = c_ST_JR;
                else if (w_is_rtype && w_funct_ok)     w_next_state = c_ST_EXEC;
                else if (w_is_branch)                  w_next_state = c_ST_BRANCH;
                else if (w_is_addi)                    w_next_state = c_ST_ADDIEX;
                else if (w_is_jump)                    w_next_state = c_ST_JUMP;
                else                                   w_next_state = c_ST_FETCH;
            end
            c_ST_MEMADR: w_next_state = w_is_load ? c_ST_MEMRD : c_ST_MEMWR;
            c_ST_MEMRD:  w_next_state = mem_ready ? c_ST_MEMWB :
                                        (w_timeout ? c_ST_FETCH : c_ST_MEMRD);
            c_ST_MEMWR:  w_next_state = (mem_ready || w_timeout) ? c_ST_FETCH : c_ST_MEMWR;
            c_ST_EXEC:   w_next_state = c_ST_ALUWB;
            c_ST_ADDIEX: w_next_state = c_ST_ADDIWB;
            default:     w_next_state = c_ST_FETCH;
        endcase
    end

    // A timeout in FETCH stays in FETCH, so the counter must be cleared explicitly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if ((w_next_state != r_state) || w_timeout)
                r_wait_cnt <= '0;
            else if (w_mem_state && !mem_ready)
                r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
        end
    end

    always_comb begin
        w_pcen = 1'b0; w_irwrite = 1'b0; w_regwrite = 1'b0; w_memread = 1'b0;
        w_memwrite = 1'b0; w_iord = 1'b0; w_alusrca = 1'b0;
        w_alusrcb = 2'b00; w_pcsrc = 2'b00; w_regdst = 2'b00; w_memtoreg = 2'b00;
        w_half = 1'b0; w_b = 1'b0; w_lbu = 1'b0;
        w_illegal = 1'b0; w_buserr = 1'b0;
        w_aluc = c_ALU_ADD;
        case (r_state)
            c_ST_FETCH: begin
                w_memread = 1'b1; w_alusrcb = 2'b01;
                w_pcen = mem_ready; w_irwrite = mem_ready; w_buserr = w_timeout;
            end
            c_ST_DECODE: begin
                w_alusrcb = 2'b11; w_illegal = !w_decode_ok;
            end
            c_ST_MEMADR: begin w_alusrca = 1'b1; w_alusrcb = 2'b10; end
            c_ST_MEMRD:  begin w_memread = 1'b1; w_iord = 1'b1; w_buserr = w_timeout; end
            c_ST_MEMWB:  begin w_regwrite = 1'b1; w_memtoreg = 2'b01; end
            c_ST_MEMWR: begin
                w_memwrite = !w_timeout; w_iord = 1'b1; w_buserr = w_timeout;
            end
            c_ST_EXEC:   begin w_alusrca = 1'b1; w_aluc = w_funct_alu; end
            c_ST_ALUWB:  begin w_regwrite = 1'b1; w_regdst = 2'b01; end
            c_ST_ADDIEX: begin w_alusrca = 1'b1; w_alusrcb = 2'b10; end
            c_ST_ADDIWB: w_regwrite = 1'b1;
            c_ST_BRANCH: begin
                w_alusrca = 1'b1; w_aluc = c_ALU_SUB; w_pcsrc = 2'b01;
                w_pcen = zero ^ (op == c_OP_BNE);
            end
            c_ST_JUMP: begin
                w_pcsrc = 2'b10; w_pcen = 1'b1;
                if (w_is_jal) begin
                    w_regwrite = 1'b1; w_regdst = 2'b10; w_memtoreg = 2'b10;
                end
            end
            c_ST_JR:     begin w_pcsrc = 2'b11; w_pcen = 1'b1; end
            default:     ;
        endcase
        if ((r_state == c_ST_MEMRD) || (r_state == c_ST_MEMWB) || (r_state == c_ST_MEMWR)) begin
            w_half = (op == c_OP_LH) || (op == c_OP_SH);
            w_b    = (op == c_OP_LB) || (op == c_OP_SB) || (op == c_OP_LBU);
            w_lbu  = (op == c_OP_LBU);
        end
    end

    // Outputs are gated by reset so strobes drop the instant reset asserts.
    assign pcen     = reset & w_pcen;
    assign irwrite  = reset & w_irwrite;
    assign regwrite = reset & w_regwrite;
    assign memread  = reset & w_memread;
    assign memwrite = reset & w_memwrite;
    assign iord     = reset & w_iord;
    assign alusrca  = reset & w_alusrca;
    assign alusrcb  = reset ? w_alusrcb  : 2'b00;
    assign pcsrc    = reset ? w_pcsrc    : 2'b00;
    assign regdst   = reset ? w_regdst   : 2'b00;
    assign memtoreg = reset ? w_memtoreg : 2'b00;
    assign half     = reset & w_half;
    assign b        = reset & w_b;
    assign lbu      = reset & w_lbu;
    assign illegal  = reset & w_illegal;
    assign buserr   = reset & w_buserr;
    assign state    = reset ? r_state : 4'd0;

    assign w_aluc_gated = reset ? w_aluc : 4'b0000;

    generate
        if (ALUCTRL_W > 4) begin : g_aluc_pad
            assign alucontrol = {{(ALUCTRL_W-4){1'b0}}, w_aluc_gated};
        end else begin : g_aluc_exact
            assign alucontrol = w_aluc_gated;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Self-checking bench for multicycle_controller with a phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    localparam int MAXW = 3;

    localparam logic [3:0] P_FETCH = 4'd0,  P_DECODE = 4'd1,  P_MEMADR = 4'd2, P_MEMRD = 4'd3;
    localparam logic [3:0] P_MEMWB = 4'd4,  P_MEMWR = 4'd5,   P_EXEC = 4'd6,   P_ALUWB = 4'd7;
    localparam logic [3:0] P_ADDIEX = 4'd8, P_ADDIWB = 4'd9,  P_BRANCH = 4'd10;
    localparam logic [3:0] P_JUMP = 4'd11,  P_JR = 4'd12;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_LH = 6'b100001;
    localparam logic [5:0] OP_LB = 6'b100000, OP_LBU = 6'b100100, OP_SW = 6'b101011;
    localparam logic [5:0] OP_SH = 6'b101001, OP_SB = 6'b101000, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011, OP_BAD = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010, FN_NOR = 6'b100111;
    localparam logic [5:0] FN_XOR = 6'b100110, FN_JR = 6'b001000, FN_BAD = 6'b000001;

    typedef struct packed {
        logic       pcen, irwrite, regwrite, memread, memwrite, iord, alusrca;
        logic [1:0] alusrcb, pcsrc, regdst, memtoreg;
        logic       half, b, lbu;
        logic [3:0] aluc;
        logic       illegal, buserr;
        logic [3:0] state;
    } outs_t;

    logic       r_clk = 1'b0, r_reset = 1'b1;
    logic [5:0] r_op = '0, r_funct = '0;
    logic       r_zero = 1'b0, r_mem_ready = 1'b0;

    logic       w_pcen, w_irwrite, w_regwrite, w_memread, w_memwrite, w_iord, w_alusrca;
    logic [1:0] w_alusrcb, w_pcsrc, w_regdst, w_memtoreg;
    logic       w_half, w_b, w_lbu, w_illegal, w_buserr;
    logic [3:0] w_alucontrol, w_state;

    logic       n_pcen, n_irwrite, n_regwrite, n_memread, n_memwrite, n_iord, n_alusrca;
    logic [1:0] n_alusrcb, n_pcsrc, n_regdst, n_memtoreg;
    logic       n_half, n_b, n_lbu, n_illegal, n_buserr;
    logic [3:0] n_alucontrol, n_state;

    outs_t w_obs;
    assign w_obs = {w_pcen, w_irwrite, w_regwrite, w_memread, w_memwrite, w_iord, w_alusrca,
                    w_alusrcb, w_pcsrc, w_regdst, w_memtoreg, w_half, w_b, w_lbu,
                    w_alucontrol, w_illegal, w_buserr, w_state};

    int   checks = 0, failures = 0;
    int   n_regwr = 0, n_buserr_cnt = 0;
    int   pct = 100;
    logic q_rdy[$];

    always #5 r_clk = ~r_clk;

    multicycle_controller #(.ALUCTRL_W(4), .ENABLE_LINK(1'b1), .MAX_WAIT(MAXW)) dut (
        .clk(r_clk), .reset(r_reset), .op(r_op), .funct(r_funct), .zero(r_zero),
        .mem_ready(r_mem_ready), .pcen(w_pcen), .irwrite(w_irwrite), .regwrite(w_regwrite),
        .memread(w_memread), .memwrite(w_memwrite), .iord(w_iord), .alusrca(w_alusrca),
        .alusrcb(w_alusrcb), .pcsrc(w_pcsrc), .regdst(w_regdst), .memtoreg(w_memtoreg),
        .half(w_half), .b(w_b), .lbu(w_lbu), .alucontrol(w_alucontrol),
        .illegal(w_illegal), .buserr(w_buserr), .state(w_state)
    );

    multicycle_controller #(.ALUCTRL_W(4), .ENABLE_LINK(1'b0), .MAX_WAIT(0)) dut_nolink (
        .clk(r_clk), .reset(r_reset), .op(r_op), .funct(r_funct), .zero(r_zero),
        .mem_ready(r_mem_ready), .pcen(n_pcen), .irwrite(n_irwrite), .regwrite(n_regwrite),
        .memread(n_memread), .memwrite(n_memwrite), .iord(n_iord), .alusrca(n_alusrca),
        .alusrcb(n_alusrcb), .pcsrc(n_pcsrc), .regdst(n_regdst), .memtoreg(n_memtoreg),
        .half(n_half), .b(n_b), .lbu(n_lbu), .alucontrol(n_alucontrol),
        .illegal(n_illegal), .buserr(n_buserr), .state(n_state)
    );

    task automatic check(input outs_t exp, input string tag);
        checks++;
        assert (w_obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, w_obs, exp);
        end
    endtask

    task automatic chk_val(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] alu_of(input logic [5:0] f);
        case (f)
            FN_SUB:  return 4'b0110;
            FN_AND:  return 4'b0000;
            FN_OR:   return 4'b0001;
            FN_SLT:  return 4'b0111;
            FN_NOR:  return 4'b1100;
            FN_XOR:  return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    // Spec output table: what each phase drives for this instruction.
    function automatic outs_t exp_out(input logic [3:0] ph, input logic [5:0] o, input logic [5:0] f,
                                      input logic z, input logic rdy, input logic tmo, input logic ill);
        outs_t e;
        e = '0;
        e.aluc  = 4'b0010;
        e.state = ph;
        case (ph)
            P_FETCH:  begin e.memread = 1; e.alusrcb = 2'b01; e.pcen = rdy; e.irwrite = rdy;
                            e.buserr = tmo; end
            P_DECODE: begin e.alusrcb = 2'b11; e.illegal = ill; end
            P_MEMADR: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            P_MEMRD:  begin e.memread = 1; e.iord = 1; e.buserr = tmo; end
            P_MEMWB:  begin e.regwrite = 1; e.memtoreg = 2'b01; end
            P_MEMWR:  begin e.memwrite = !tmo; e.iord = 1; e.buserr = tmo; end
            P_EXEC:   begin e.alusrca = 1; e.aluc = alu_of(f); end
            P_ALUWB:  begin e.regwrite = 1; e.regdst = 2'b01; end
            P_ADDIEX: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            P_ADDIWB: e.regwrite = 1;
            P_BRANCH: begin e.alusrca = 1; e.aluc = 4'b0110; e.pcsrc = 2'b01;
                            e.pcen = z ^ (o == OP_BNE); end
            P_JUMP:   begin e.pcsrc = 2'b10; e.pcen = 1;
                            if (o == OP_JAL) begin
                                e.regwrite = 1; e.regdst = 2'b10; e.memtoreg = 2'b10;
                            end
                      end
            P_JR:     begin e.pcsrc = 2'b11; e.pcen = 1; end
            default:  ;
        endcase
        if (ph == P_MEMRD || ph == P_MEMWB || ph == P_MEMWR) begin
            e.half = (o == OP_LH) || (o == OP_SH);
            e.b    = (o == OP_LB) || (o == OP_SB) || (o == OP_LBU);
            e.lbu  = (o == OP_LBU);
        end
        return e;
    endfunction

    function automatic logic next_ready();
        if (q_rdy.size() > 0) return q_rdy.pop_front();
        return ($urandom_range(0, 99) < pct);
    endfunction

    // Runs one instruction from FETCH; bench sits at posedge+1 on entry and exit.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input string tag);
        logic [3:0] ph[$];
        bit ill;
        int i, cnt, guard;
        ill = 0; i = 0; cnt = 0; guard = 0;
        ph.push_back(P_FETCH);
        ph.push_back(P_DECODE);
        case (o)
            OP_R: begin
                if (f == FN_JR) ph.push_back(P_JR);
                else if (f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_NOR, FN_XOR}) begin
                    ph.push_back(P_EXEC); ph.push_back(P_ALUWB);
                end else ill = 1;
            end
            OP_LW, OP_LH, OP_LB, OP_LBU: begin
                ph.push_back(P_MEMADR); ph.push_back(P_MEMRD); ph.push_back(P_MEMWB);
            end
            OP_SW, OP_SH, OP_SB: begin ph.push_back(P_MEMADR); ph.push_back(P_MEMWR); end
            OP_BEQ, OP_BNE: ph.push_back(P_BRANCH);
            OP_ADDI: begin ph.push_back(P_ADDIEX); ph.push_back(P_ADDIWB); end
            OP_J, OP_JAL: ph.push_back(P_JUMP);
            default: ill = 1;
        endcase
        r_op = o; r_funct = f; r_zero = z;
        n_regwr = 0; n_buserr_cnt = 0;
        while (i < ph.size()) begin
            logic rdy;
            bit is_mem, tmo;
            outs_t e;
            rdy = next_ready();
            r_mem_ready = rdy;
            is_mem = (ph[i] == P_FETCH) || (ph[i] == P_MEMRD) || (ph[i] == P_MEMWR);
            tmo = is_mem && !rdy && (cnt == MAXW);
            e = exp_out(ph[i], o, f, z, rdy, tmo, ill && (ph[i] == P_DECODE));
            @(negedge r_clk);
            check(e, tag);
            n_regwr += int'(w_regwrite);
            n_buserr_cnt += int'(w_buserr);
            @(posedge r_clk); #1;
            if (tmo) begin
                cnt = 0;
                if (ph[i] != P_FETCH) i = ph.size();
            end else if (is_mem && !rdy) cnt++;
            else begin cnt = 0; i++; end
            guard++;
            if (guard > 200) begin
                checks++; failures++;
                $error("FAIL %s cycle budget exceeded", tag);
                i = ph.size();
            end
        end
    endtask

    task automatic apply_reset();
        outs_t z0;
        z0 = '0;
        r_reset = 1'b0; r_mem_ready = 1'b0;
        repeat (2) @(posedge r_clk);
        @(negedge r_clk);
        check(z0, "reset_outputs");
        chk_val(32'(n_state), 32'd0, "reset_state_nolink");
        @(posedge r_clk); #1;
        r_reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] itab[22];
        outs_t z0;
        z0 = '0;
        itab = '{{OP_R, FN_ADD}, {OP_R, FN_SUB}, {OP_R, FN_AND}, {OP_R, FN_OR}, {OP_R, FN_SLT},
                 {OP_R, FN_NOR}, {OP_R, FN_XOR}, {OP_R, FN_JR}, {OP_R, FN_BAD}, {OP_LW, 6'd0},
                 {OP_LH, 6'd0}, {OP_LB, 6'd0}, {OP_LBU, 6'd0}, {OP_SW, 6'd0}, {OP_SH, 6'd0},
                 {OP_SB, 6'd0}, {OP_BEQ, 6'd0}, {OP_BNE, 6'd0}, {OP_ADDI, 6'd0}, {OP_J, 6'd0},
                 {OP_JAL, 6'd0}, {OP_BAD, 6'd0}};

        #2 r_reset = 1'b0;
        @(posedge r_clk); #1;
        apply_reset();

        pct = 100;
        run_instr(OP_R, FN_ADD, 1'b0, "add");
        run_instr(OP_R, FN_XOR, 1'b0, "xor");

        q_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        run_instr(OP_LW, 6'd0, 1'b0, "lw_wait3");
        chk_val(n_regwr, 1, "lw_regwrite_once");

        run_instr(OP_BEQ, 6'd0, 1'b1, "beq_taken");
        run_instr(OP_BNE, 6'd0, 1'b1, "bne_not_taken");
        run_instr(OP_BEQ, 6'd0, 1'b0, "beq_not_taken");
        run_instr(OP_BNE, 6'd0, 1'b0, "bne_taken");
        run_instr(OP_ADDI, 6'd0, 1'b0, "addi");
        run_instr(OP_J, 6'd0, 1'b0, "j");
        run_instr(OP_R, FN_JR, 1'b0, "jr");
        run_instr(OP_LBU, 6'd0, 1'b0, "lbu");
        run_instr(OP_SH, 6'd0, 1'b0, "sh");
        run_instr(OP_BAD, 6'd0, 1'b0, "illegal_op");
        run_instr(OP_R, FN_BAD, 1'b0, "illegal_funct");

        // jal on both link configurations side by side
        apply_reset();
        r_op = OP_JAL; r_funct = 6'd0; r_mem_ready = 1'b1;
        @(negedge r_clk);
        chk_val(32'(n_state), 32'd0, "nolink_fetch");
        @(posedge r_clk); #1;
        @(negedge r_clk);
        chk_val(32'(n_illegal), 32'd1, "nolink_illegal");
        chk_val(32'(w_illegal), 32'd0, "link_no_illegal");
        @(posedge r_clk); #1;
        @(negedge r_clk);
        chk_val(32'(n_state), 32'd0, "nolink_back_to_fetch");
        chk_val(32'(w_state), 32'd11, "jal_state");
        chk_val({w_pcen, w_regwrite, w_regdst, w_memtoreg}, {26'd0, 6'b111010}, "jal_outputs");
        @(posedge r_clk); #1;
        @(negedge r_clk);
        chk_val(32'(w_state), 32'd0, "jal_done");
        @(posedge r_clk); #1;
        apply_reset();

        q_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        run_instr(OP_SW, 6'd0, 1'b0, "sw_timeout");
        chk_val(n_buserr_cnt, 1, "sw_buserr_count");
        q_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        run_instr(OP_SW, 6'd0, 1'b0, "sw_ready_at_limit");
        chk_val(n_buserr_cnt, 0, "sw_no_buserr");
        q_rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run_instr(OP_LW, 6'd0, 1'b0, "fetch_timeout_refetch");
        chk_val(n_buserr_cnt, 1, "fetch_buserr_count");

        // reset while a store strobe is active
        r_op = OP_SW; r_funct = 6'd0; r_mem_ready = 1'b1;
        repeat (3) begin @(posedge r_clk); #1; end
        r_mem_ready = 1'b0;
        @(negedge r_clk);
        chk_val(32'(w_memwrite), 32'd1, "memwrite_before_reset");
        #2 r_reset = 1'b0;
        #1 check(z0, "async_reset_in_memwr");
        @(posedge r_clk); #1;
        r_reset = 1'b1;
        run_instr(OP_R, FN_ADD, 1'b0, "after_reset_add");

        pct = 70;
        for (int k = 0; k < 60; k++) begin
            logic [11:0] ent;
            logic [5:0]  fsel;
            ent  = itab[$urandom_range(0, 21)];
            fsel = (ent[11:6] == OP_R) ? ent[5:0] : 6'($urandom);
            run_instr(ent[11:6], fsel, 1'($urandom), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
